pc_fetch_sequencer: RTL and testbench

//  Sequences the program counter and instruction fetch for the single-issue datapath.
//  - Owns the PC register.
//  - Runs a req/ack handshake to instruction memory.
//  - Waits for the datapath to finish each instruction.
//  - Resolves branch/jump redirects and implements halt/resume.

---
 rtl/pc_fetch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// PC owner and fetch/execute sequencer: req/ack fetch, wait for exec_done, resolve redirects, halt/resume.
// Optional fetch-timeout fault is compiled in with `define PCSEQ_TIMEOUT_EN.
module pc_fetch_sequencer #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              brancheq,
  input  logic              branchneq,
  input  logic              zero,
  input  logic              jump,
  input  logic [ADDR_W-1:0] target,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] next_pc;

`ifdef PCSEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  // branchneq outranks brancheq, which outranks jump
  always_comb begin
    next_pc = pc_q + ADDR_W'(1);
    if (branchneq) begin
      if (!zero) next_pc = target;
    end else if (brancheq) begin
      if (zero) next_pc = target;
    end else if (jump) begin
      next_pc = target;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = 1'b0;
    valid_d  = 1'b0;
    halted_d = 1'b0;
`ifdef PCSEQ_TIMEOUT_EN
    cnt_d    = cnt_q;
    fault_d  = fault_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
`ifdef PCSEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      FETCH: begin
        if (imem_ack) begin
          state_d = EXEC;
          valid_d = 1'b1;
        end else begin
          req_d = 1'b1;
`ifdef PCSEQ_TIMEOUT_EN
          if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d = FAULT;
            fault_d = 1'b1;
            req_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      EXEC: begin
        if (exec_done) begin
          pc_d = next_pc;
          if (halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            state_d = FETCH;
            req_d   = 1'b1;
`ifdef PCSEQ_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      HALT: begin
        if (resume) begin
          state_d = FETCH;
          req_d   = 1'b1;
`ifdef PCSEQ_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          halted_d = 1'b1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
`ifdef PCSEQ_TIMEOUT_EN
      cnt_q    <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
`ifdef PCSEQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign state       = state_q;
`ifdef PCSEQ_TIMEOUT_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed scenarios plus randomized instruction stream vs. a PC model.
module tb_pc_fetch_sequencer;
  localparam int                ADDR_W   = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic              instr_valid;
  logic              exec_done = 1'b0;
  logic              brancheq = 1'b0;
  logic              branchneq = 1'b0;
  logic              zero = 1'b0;
  logic              jump = 1'b0;
  logic [ADDR_W-1:0] target = '0;
  logic              halt = 1'b0;
  logic              resume = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              fault;
  logic [2:0]        state;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int valid_cyc = 0;
  logic [ADDR_W-1:0] m_pc;

  pc_fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .TIMEOUT_CYC(16)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .instr_valid(instr_valid), .exec_done(exec_done),
    .brancheq(brancheq), .branchneq(branchneq), .zero(zero), .jump(jump),
    .target(target), .halt(halt), .resume(resume), .pc(pc), .halted(halted),
    .fault(fault), .state(state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural PC rule: conditional branches first, then jump, else sequential (modulo 2^ADDR_W)
  function automatic logic [ADDR_W-1:0] model_next(input logic [ADDR_W-1:0] cur,
      input logic bne, input logic beq, input logic z, input logic j,
      input logic [ADDR_W-1:0] tgt);
    longint unsigned seq;
    seq = (longint'(cur) + 1) % (64'd1 << ADDR_W);
    if (bne) return z ? ADDR_W'(seq) : tgt;
    if (beq) return z ? tgt : ADDR_W'(seq);
    if (j)   return tgt;
    return ADDR_W'(seq);
  endfunction

  task automatic scramble_ignored();
    brancheq  = 1'($urandom);
    branchneq = 1'($urandom);
    zero      = 1'($urandom);
    jump      = 1'($urandom);
    halt      = 1'($urandom);
    target    = ADDR_W'($urandom);
  endtask

  // One instruction: wait for request, ack after ad cycles, exec_done after dd cycles
  task automatic do_instr(input int ad, input int dd, input logic bne, input logic beq,
      input logic z, input logic j, input logic [ADDR_W-1:0] tgt, input logic h,
      input logic res_at_done);
    int budget;
    budget = 50;
    imem_ack = 1'b0;
    while (!imem_req && budget > 0) begin
      step();
      budget--;
    end
    check("req_wait", imem_req, 1'b1);
    check("fetch_addr", imem_addr, m_pc);
    check("fetch_state", state, 3'd1);
    for (int i = 0; i < ad; i++) begin
      step();
      check("req_held", imem_req, 1'b1);
      check("addr_held", imem_addr, m_pc);
    end
    imem_ack = 1'b1;
    step();
    valid_cyc = cyc;
    check("valid_pulse", instr_valid, 1'b1);
    check("req_drop", imem_req, 1'b0);
    check("exec_state", state, 3'd2);
    for (int i = 0; i < dd; i++) begin
      imem_ack = 1'($urandom);
      resume   = 1'($urandom);
      scramble_ignored();
      step();
      check("valid_once", instr_valid, 1'b0);
      check("exec_wait", state, 3'd2);
      check("exec_pc", pc, m_pc);
    end
    imem_ack  = 1'($urandom);
    exec_done = 1'b1;
    branchneq = bne;
    brancheq  = beq;
    zero      = z;
    jump      = j;
    target    = tgt;
    halt      = h;
    resume    = res_at_done;
    step();
    exec_done = 1'b0;
    resume    = 1'b0;
    imem_ack  = 1'b0;
    m_pc = model_next(m_pc, bne, beq, z, j, tgt);
    check("commit_pc", pc, m_pc);
    if (h) begin
      check("halt_state", state, 3'd3);
      check("halted", halted, 1'b1);
      check("halt_noreq", imem_req, 1'b0);
    end else begin
      check("next_req", imem_req, 1'b1);
      check("next_addr", imem_addr, m_pc);
    end
  endtask

  task automatic halt_then_resume(input int wait_cyc);
    for (int i = 0; i < wait_cyc; i++) begin
      imem_ack  = 1'($urandom);
      exec_done = 1'($urandom);
      scramble_ignored();
      step();
      check("halt_hold", halted, 1'b1);
      check("halt_noreq", imem_req, 1'b0);
      check("halt_pc", pc, m_pc);
    end
    exec_done = 1'b0;
    imem_ack  = 1'b0;
    resume    = 1'b1;
    step();
    resume = 1'b0;
    check("resume_req", imem_req, 1'b1);
    check("resume_addr", imem_addr, m_pc);
    check("resume_unhalt", halted, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    check("rst_state", state, 3'd0);
    check("rst_pc", pc, RESET_PC);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_fault", fault, 1'b0);
    reset = 1'b1;
    m_pc  = RESET_PC;
  endtask

  initial begin
    int prev;
    m_pc = RESET_PC;
    do_reset();
    step();
    check("idle_to_fetch", state, 3'd1);

    // Back-to-back instructions at full rate: addresses 0,1,2,3, a pulse every 2 cycles
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", imem_addr, 64'(i));
      do_instr(0, 0, 0, 0, 0, 0, '0, 0, 0);
      if (i > 0) check("throughput", 64'(valid_cyc - prev), 64'd2);
      prev = valid_cyc;
    end

    // Conditional branches
    do_instr(0, 1, 0, 0, 0, 1, 32'd5, 0, 0);
    do_instr(1, 0, 0, 1, 1, 0, 32'd20, 0, 0);
    check("beq_taken", imem_addr, 64'd20);
    do_instr(0, 0, 0, 0, 0, 1, 32'd5, 0, 0);
    do_instr(0, 2, 0, 1, 0, 0, 32'd20, 0, 0);
    check("beq_not_taken", imem_addr, 64'd6);
    do_instr(2, 0, 1, 0, 0, 0, 32'd40, 0, 0);
    check("bne_taken", imem_addr, 64'd40);

    // Priority and wrap
    do_instr(0, 0, 1, 0, 1, 1, 32'h100, 0, 0);
    check("bne_over_jump", imem_addr, 64'd41);
    do_instr(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    do_instr(0, 0, 0, 0, 0, 0, 32'h1234, 0, 0);
    check("pc_wrap", imem_addr, 64'd0);

    // Halt at pc=7, halt beats a simultaneous resume
    do_instr(0, 0, 0, 0, 0, 1, 32'd7, 0, 0);
    do_instr(0, 0, 0, 0, 0, 0, '0, 1, 1);
    check("halt_pc8", pc, 64'd8);
    halt_then_resume(10);
    check("resume_addr8", imem_addr, 64'd8);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic h;
      h = ($urandom_range(0, 7) == 0);
      do_instr($urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), ADDR_W'($urandom), h, 1'($urandom));
      if (h) halt_then_resume($urandom_range(0, 6));
    end

    // Asynchronous reset mid-fetch with ack pending
    check("pre_rst_req", imem_req, 1'b1);
    imem_ack = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("async_req_drop", imem_req, 1'b0);
    check("async_state", state, 3'd0);
    check("async_pc", pc, RESET_PC);
    step();
    step();
    reset = 1'b1;
    m_pc  = RESET_PC;
    step();
    imem_ack = 1'b0;
    check("ack_in_idle_ignored", instr_valid, 1'b0);
    check("post_rst_fetch", state, 3'd1);
    check("post_rst_addr", imem_addr, RESET_PC);
    do_instr(0, 0, 0, 0, 0, 0, '0, 0, 0);

    // Fetch with ack withheld
    imem_ack = 1'b0;
`ifdef PCSEQ_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step();
    check("pre_timeout_state", state, 3'd1);
    check("pre_timeout_fault", fault, 1'b0);
    step();
    check("timeout_state", state, 3'd4);
    check("timeout_fault", fault, 1'b1);
    check("timeout_noreq", imem_req, 1'b0);
    imem_ack = 1'b1;
    resume   = 1'b1;
    for (int i = 0; i < 5; i++) step();
    imem_ack = 1'b0;
    resume   = 1'b0;
    check("fault_sticky", fault, 1'b1);
    check("fault_state_sticky", state, 3'd4);
    do_reset();
    check("fault_cleared", fault, 1'b0);
`else
    for (int i = 0; i < 100; i++) step();
    check("no_timeout_state", state, 3'd1);
    check("no_timeout_fault", fault, 1'b0);
    check("no_timeout_req", imem_req, 1'b1);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("late_ack_exec", state, 3'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
